sd_cmd_engine: RTL and testbench



---
 rtl/sd_cmd_engine.sv | 197 +++++++++++++++++++
 tb/tb_sd_cmd_engine.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_engine.sv
// SD card CMD-line engine, native 1-bit mode: generates SD_CLK, sends a 48-bit
// command frame with CRC7 and captures/checks the optional 48-bit response.
module sd_cmd_engine #(
    parameter int CLK_DIV      = 63,
    parameter int INIT_CLKS    = 80,
    parameter int RESP_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        resp_en,
    input  logic        resp_nocrc,
    output logic        resp_valid,
    output logic [5:0]  resp_index,
    output logic [31:0] resp_arg,
    output logic        resp_crc_err,
    output logic        resp_timeout,
    output logic        sd_clk,
    output logic        sd_cmd_out,
    output logic        sd_cmd_oe,
    input  logic        sd_cmd_in
);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_TX, S_WAIT, S_RX, S_NRC, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  div_q;
    logic [7:0]  cnt_q;
    logic [1:0]  sync_q;
    logic [47:0] tx_sr;
    logic [47:0] rx_sr;
    logic [39:0] cmd_head;
    logic        resp_en_q, nocrc_q, got_q, timeout_q;
    logic        running, cnt_inc, tick, rise, fall, accept, cmd_sync;

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    assign cmd_head = {2'b01, cmd_index, cmd_arg};
    assign cmd_sync = sync_q[1];
    assign tick     = running && (div_q == 8'(CLK_DIV - 1));
    assign rise     = tick && !sd_clk;
    assign fall     = tick && sd_clk;
    assign accept   = cmd_ready && cmd_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_INIT;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT: if (fall && cnt_q == 8'(INIT_CLKS)) state_d = S_IDLE;
            S_IDLE: if (cmd_valid) state_d = S_TX;
            S_TX:   if (fall && cnt_q == 8'd47) state_d = resp_en_q ? S_WAIT : S_NRC;
            S_WAIT: if (rise) begin
                        if (!cmd_sync)                              state_d = S_RX;
                        else if (cnt_q == 8'(RESP_TIMEOUT - 1)) state_d = S_NRC;
                    end
            S_RX:   if (rise && cnt_q == 8'd46) state_d = S_NRC;
            S_NRC:  if (fall && cnt_q == 8'd8) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
    end

    // INIT/WAIT/RX/NRC count rising edges, TX counts falling edges (bits placed).
    always_comb begin
        running    = 1'b0;
        cnt_inc    = 1'b0;
        cmd_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            S_INIT: begin running = 1'b1; cnt_inc = rise; end
            S_IDLE: cmd_ready = 1'b1;
            S_TX:   begin running = 1'b1; cnt_inc = fall; end
            S_WAIT, S_RX, S_NRC: begin running = 1'b1; cnt_inc = rise; end
            S_DONE: resp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q  <= '0;
            sd_clk <= 1'b0;
        end else if (!running) begin
            div_q  <= '0;
            sd_clk <= 1'b0;
        end else if (tick) begin
            div_q  <= '0;
            sd_clk <= ~sd_clk;
        end else begin
            div_q  <= div_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)               cnt_q <= '0;
        else if (state_d != state_q) cnt_q <= '0;
        else if (cnt_inc)           cnt_q <= cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= 2'b11;
        else          sync_q <= {sync_q[0], sd_cmd_in};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sd_cmd_out <= 1'b1;
            sd_cmd_oe  <= 1'b0;
        end else begin
            case (state_q)
                S_INIT: begin sd_cmd_oe <= 1'b1; sd_cmd_out <= 1'b1; end
                S_IDLE: begin
                    sd_cmd_oe  <= 1'b1;
                    sd_cmd_out <= accept ? cmd_head[39] : 1'b1;
                end
                S_TX: if (fall) begin
                    if (cnt_q == 8'd47) begin
                        sd_cmd_oe  <= 1'b0;
                        sd_cmd_out <= 1'b1;
                    end else begin
                        sd_cmd_out <= tx_sr[47];
                    end
                end
                S_NRC: if (fall) begin sd_cmd_oe <= 1'b1; sd_cmd_out <= 1'b1; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            got_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else if (accept) begin
            got_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else if (state_q == S_WAIT && rise) begin
            if (!cmd_sync)                              got_q     <= 1'b1;
            else if (cnt_q == 8'(RESP_TIMEOUT - 1)) timeout_q <= 1'b1;
        end
    end

    // tx_sr holds the bits still to be sent, MSB next.
    always_ff @(posedge clk) begin
        if (accept) begin
            tx_sr     <= {cmd_head[38:0], crc7(cmd_head), 1'b1, 1'b0};
            resp_en_q <= resp_en;
            nocrc_q   <= resp_nocrc;
        end else if (state_q == S_TX && fall) begin
            tx_sr     <= {tx_sr[46:0], 1'b0};
        end
        if ((state_q == S_WAIT || state_q == S_RX) && rise)
            rx_sr <= {rx_sr[46:0], cmd_sync};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_index   <= '0;
            resp_arg     <= '0;
            resp_crc_err <= 1'b0;
            resp_timeout <= 1'b0;
        end else if (state_q == S_NRC && state_d == S_DONE) begin
            if (got_q) begin
                resp_index   <= rx_sr[45:40];
                resp_arg     <= rx_sr[39:8];
                resp_crc_err <= rx_sr[46] | ~rx_sr[0] |
                                (~nocrc_q & (crc7(rx_sr[47:8]) != rx_sr[7:1]));
                resp_timeout <= 1'b0;
            end else begin
                resp_index   <= '0;
                resp_arg     <= '0;
                resp_crc_err <= 1'b0;
                resp_timeout <= timeout_q;
            end
        end
    end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Testbench for sd_cmd_engine: scoreboard of expected wire frames and response
// results, with a simple card model driving the CMD input.
module tb_sd_cmd_engine;

    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        resp_en;
    logic        resp_nocrc;
    logic        resp_valid;
    logic [5:0]  resp_index;
    logic [31:0] resp_arg;
    logic        resp_crc_err;
    logic        resp_timeout;
    logic        sd_clk;
    logic        sd_cmd_out;
    logic        sd_cmd_oe;
    logic        sd_cmd_in;

    int errors = 0;
    int checks = 0;

    logic [47:0] frame_q[$];
    logic [39:0] resp_q[$];   // {index, arg, crc_err, timeout}

    always #5 clk = ~clk;

    sd_cmd_engine #(.CLK_DIV(CLK_DIV), .INIT_CLKS(80), .RESP_TIMEOUT(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_index(cmd_index), .cmd_arg(cmd_arg),
        .resp_en(resp_en), .resp_nocrc(resp_nocrc),
        .resp_valid(resp_valid), .resp_index(resp_index), .resp_arg(resp_arg),
        .resp_crc_err(resp_crc_err), .resp_timeout(resp_timeout),
        .sd_clk(sd_clk), .sd_cmd_out(sd_cmd_out), .sd_cmd_oe(sd_cmd_oe),
        .sd_cmd_in(sd_cmd_in)
    );

    // CRC7 as the remainder of {data, 7'b0} divided by x^7+x^3+1.
    function automatic logic [6:0] crc7_model(input logic [39:0] d);
        logic [46:0] r;
        r = {d, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    function automatic logic [47:0] mk_frame(input logic [7:0] first, input logic [31:0] arg);
        return {first, arg, crc7_model({first, arg}), 1'b1};
    endfunction

    task automatic wait_edge(input logic lvl);
        logic prev;
        bit   seen;
        prev = sd_clk;
        seen = 0;
        for (int i = 0; i < 8 * CLK_DIV; i++) begin
            @(negedge clk);
            if (sd_clk === lvl && prev !== lvl) begin seen = 1; break; end
            prev = sd_clk;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL sd_clk_edge: no transition to %0b within %0d cycles", lvl, 8 * CLK_DIV);
        end
    endtask

    task automatic send(input logic [5:0] idx, input logic [31:0] arg, input bit ren,
                        input bit nocrc, input bit hold);
        bit rdy;
        @(negedge clk);
        cmd_index = idx; cmd_arg = arg; resp_en = ren; resp_nocrc = nocrc;
        cmd_valid = 1'b1;
        rdy = 0;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready === 1'b1) begin rdy = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!rdy) begin errors++; $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready); end
        @(posedge clk);
        #1;
        if (hold) begin cmd_index = 6'h03; cmd_arg = 32'hFFFF_FFFF; end
        else cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit ren,
                           input bit nocrc, input bit hold, input bit card_on,
                           input logic [47:0] card_resp, input int dly,
                           input logic [47:0] exp_frame, input logic [39:0] exp_resp,
                           input int exp_rises);
        logic [47:0] bits;
        logic [47:0] ef;
        logic [39:0] er;
        int          bad;
        int          rises;
        bit          done;
        frame_q.push_back(exp_frame);
        resp_q.push_back(exp_resp);
        send(idx, arg, ren, nocrc, hold);
        bits = '0; bad = 0;
        for (int i = 0; i < 48; i++) begin
            wait_edge(1'b1);
            bits = {bits[46:0], sd_cmd_out};
            if (sd_cmd_oe !== 1'b1) bad++;
        end
        if (hold) cmd_valid = 1'b0;
        ef = frame_q.pop_front();
        checks++;
        if (bits !== ef) begin errors++; $display("FAIL tx_frame: got %h required %h", bits, ef); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL tx_oe: %0d bits with oe low, required 0", bad); end
        wait_edge(1'b0);
        checks++;
        if (sd_cmd_oe !== 1'b0) begin errors++; $display("FAIL turnaround_oe: got %b required 0", sd_cmd_oe); end
        rises = 0; done = 0;
        fork
            begin : card
                if (card_on) begin
                    repeat (dly) wait_edge(1'b0);
                    sd_cmd_in = card_resp[47];
                    for (int i = 46; i >= 0; i--) begin
                        wait_edge(1'b0);
                        sd_cmd_in = card_resp[i];
                    end
                    wait_edge(1'b0);
                    sd_cmd_in = 1'b1;
                end
            end
            begin : mon
                logic prev;
                prev = sd_clk;
                for (int i = 0; i < 4000; i++) begin
                    @(negedge clk);
                    if (sd_clk && !prev) rises++;
                    prev = sd_clk;
                    if (resp_valid === 1'b1) begin done = 1; break; end
                end
            end
        join
        er = resp_q.pop_front();
        checks++;
        if (!done) begin errors++; $display("FAIL resp_valid_seen: got 0 required 1"); end
        checks++;
        if (rises != exp_rises) begin
            errors++; $display("FAIL sd_clk_rises: got %0d required %0d", rises, exp_rises);
        end
        checks++;
        if ({resp_index, resp_arg, resp_crc_err, resp_timeout} !== er) begin
            errors++;
            $display("FAIL resp_fields: got idx=%h arg=%h crc=%b to=%b required idx=%h arg=%h crc=%b to=%b",
                     resp_index, resp_arg, resp_crc_err, resp_timeout, er[39:34], er[33:2], er[1], er[0]);
        end
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ready_with_valid: got %b required 0", cmd_ready); end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL valid_pulse: valid=%b ready=%b required 0 1", resp_valid, cmd_ready);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({sd_clk, sd_cmd_out, sd_cmd_oe} !== 3'b010) begin
            errors++; $display("FAIL reset_pins: clk/out/oe=%b required 010", {sd_clk, sd_cmd_out, sd_cmd_oe});
        end
        checks++;
        if ({cmd_ready, resp_valid} !== 2'b00) begin
            errors++; $display("FAIL reset_handshake: ready/valid=%b required 00", {cmd_ready, resp_valid});
        end
        checks++;
        if ({resp_index, resp_arg, resp_crc_err, resp_timeout} !== 40'd0) begin
            errors++; $display("FAIL reset_fields: got %h required 0", {resp_index, resp_arg, resp_crc_err, resp_timeout});
        end
    endtask

    task automatic test_init();
        int   rises;
        int   bad;
        logic prev;
        bit   rdy;
        reset_n = 1'b1;
        prev = sd_clk; rises = 0; bad = 0; rdy = 0;
        for (int i = 0; i < 4 * CLK_DIV * 84; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) begin rdy = 1; break; end
            if (sd_cmd_oe !== 1'b1 || sd_cmd_out !== 1'b1) bad++;
            if (sd_clk && !prev) rises++;
            prev = sd_clk;
        end
        checks++;
        if (!rdy) begin errors++; $display("FAIL init_ready: got 0 required 1"); end
        checks++;
        if (rises != 80) begin errors++; $display("FAIL init_clocks: got %0d required 80", rises); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL init_cmd_high: %0d cycles off, required 0", bad); end
        checks++;
        if (sd_clk !== 1'b0) begin errors++; $display("FAIL idle_clk: got %b required 0", sd_clk); end
    endtask

    task automatic test_cmd0();
        run_cmd(6'd0, 32'd0, 0, 0, 0, 0, 48'd0, 0, 48'h40_0000_0000_95, 40'd0, 8);
    endtask

    task automatic test_cmd8();
        run_cmd(6'd8, 32'h1AA, 1, 0, 0, 1, mk_frame(8'h08, 32'h1AA), 5,
                48'h48_0000_01AA_87, {6'd8, 32'h1AA, 2'b00}, 61);
    endtask

    task automatic test_crc_err();
        run_cmd(6'd17, 32'd0, 1, 0, 0, 1, mk_frame(8'h11, 32'h900) ^ 48'h4, 3,
                48'h51_0000_0000_55, {6'd17, 32'h900, 2'b10}, 59);
    endtask

    task automatic test_nocrc();
        run_cmd(6'd17, 32'd0, 1, 1, 0, 1, 48'h3F_80FF_8000_FF, 2,
                48'h51_0000_0000_55, {6'h3F, 32'h80FF_8000, 2'b00}, 58);
    endtask

    task automatic test_timeout();
        run_cmd(6'd8, 32'h1AA, 1, 0, 0, 0, 48'd0, 0,
                48'h48_0000_01AA_87, {38'd0, 2'b01}, 72);
    endtask

    task automatic test_last_edge_start();
        run_cmd(6'd8, 32'h1AA, 1, 0, 0, 1, mk_frame(8'h08, 32'h1AA), 63,
                48'h48_0000_01AA_87, {6'd8, 32'h1AA, 2'b00}, 119);
    endtask

    task automatic test_reset_midframe();
        send(6'd8, 32'h1AA, 1, 0, 0);
        repeat (20) wait_edge(1'b1);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({sd_clk, sd_cmd_out, sd_cmd_oe, cmd_ready, resp_valid} !== 5'b01000) begin
            errors++; $display("FAIL midframe_reset_ctrl: got %b required 01000",
                               {sd_clk, sd_cmd_out, sd_cmd_oe, cmd_ready, resp_valid});
        end
        checks++;
        if ({resp_index, resp_arg, resp_crc_err, resp_timeout} !== 40'd0) begin
            errors++; $display("FAIL midframe_reset_fields: got %h required 0",
                               {resp_index, resp_arg, resp_crc_err, resp_timeout});
        end
        repeat (3) @(negedge clk);
        test_init();
    endtask

    task automatic test_back_to_back();
        int rises;
        logic prev;
        bit   drop;
        run_cmd(6'd0, 32'd0, 0, 0, 1, 0, 48'd0, 0, 48'h40_0000_0000_95, 40'd0, 8);
        prev = sd_clk; rises = 0; drop = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sd_clk && !prev) rises++;
            if (cmd_ready !== 1'b1) drop = 1;
            prev = sd_clk;
        end
        checks++;
        if (rises != 0 || drop) begin
            errors++; $display("FAIL held_valid_single: rises=%0d ready_drop=%b required 0 0", rises, drop);
        end
        run_cmd(6'd55, 32'h1234_0000, 0, 0, 0, 0, 48'd0, 0,
                mk_frame(8'h77, 32'h1234_0000), 40'd0, 8);
    endtask

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_index = '0; cmd_arg = '0;
        resp_en = 1'b0; resp_nocrc = 1'b0; sd_cmd_in = 1'b1;
        test_reset();
        test_init();
        test_cmd0();
        test_cmd8();
        test_crc_err();
        test_nocrc();
        test_timeout();
        test_last_edge_start();
        test_reset_midframe();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
